// File: rtl/serial_comp_pkg.sv
// serial_comp_pkg
// Purpose : shared definitions for the serial MSB-first magnitude comparator.
// Contents: default operand width, FSM state encoding, one-hot result codes
//           ordered {LG, EQ, RG}.
package serial_comp_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_t;

    localparam logic [2:0] RES_LG = 3'b100;  // X > Y
    localparam logic [2:0] RES_EQ = 3'b010;  // X == Y
    localparam logic [2:0] RES_RG = 3'b001;  // X < Y

endpackage

// File: rtl/serial_comp_ctrl_if.sv
// serial_comp_ctrl_if
// Purpose : request/result bundle of the serial comparator.
// Signals : START, X, Y  - request and unsigned operands (master drives)
//           BUSY, DONE   - compare in progress / one-cycle result-valid pulse
//           LG_OUT, EQ_OUT, RG_OUT - result flags X>Y, X==Y, X<Y
// Modports: master (requester), slave (comparator).
interface serial_comp_ctrl_if
    import serial_comp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             START;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             BUSY;
    logic             DONE;
    logic             LG_OUT;
    logic             EQ_OUT;
    logic             RG_OUT;

    modport master (
        output START, X, Y,
        input  BUSY, DONE, LG_OUT, EQ_OUT, RG_OUT
    );

    modport slave (
        input  START, X, Y,
        output BUSY, DONE, LG_OUT, EQ_OUT, RG_OUT
    );

endinterface

// File: rtl/comp_bit.sv
// comp_bit
// Purpose : combinational one-bit magnitude compare.
// Ports   : XB, YB - operand bits
//           CODE   - RES_LG (XB>YB), RES_EQ (XB==YB) or RES_RG (XB<YB)
module comp_bit
    import serial_comp_pkg::*;
(
    input  logic       XB,
    input  logic       YB,
    output logic [2:0] CODE
);

    always_comb begin
        CODE = RES_EQ;
        if (XB && !YB) begin
            CODE = RES_LG;
        end else if (!XB && YB) begin
            CODE = RES_RG;
        end
    end

endmodule

// File: rtl/serial_comp_ctrl.sv
// serial_comp_ctrl
// Purpose : compares two unsigned WIDTH-bit operands one bit pair per cycle,
//           MSB first, terminating early at the first differing bit.
// Ports   : CLK - clock (rising edge)
//           RST - asynchronous active-high reset
//           bus - serial_comp_ctrl_if.slave (START/X/Y in, BUSY/DONE/flags out)
module serial_comp_ctrl
    import serial_comp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                CLK,
    input  logic                RST,
    serial_comp_ctrl_if.slave   bus
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [IDX_W-1:0]   r_idx;
    logic [2:0]         r_flags;

    logic [2:0]         w_code;
    logic               w_accept;
    logic               w_bits_eq;
    logic               w_last;
    logic               w_finish;

    // Operands are shifted left each RUN cycle, so the bit under test is always the MSB.
    comp_bit u_comp_bit (
        .XB   (r_x[WIDTH-1]),
        .YB   (r_y[WIDTH-1]),
        .CODE (w_code)
    );

    assign w_accept  = bus.START && (r_state != StRun);
    assign w_bits_eq = (w_code == RES_EQ);
    assign w_last    = (r_idx == '0);
    assign w_finish  = (r_state == StRun) && (!w_bits_eq || w_last);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (bus.START) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (!w_bits_eq || w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = bus.START ? StRun : StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_x     <= '0;
            r_y     <= '0;
            r_idx   <= '0;
            r_flags <= '0;
        end else if (w_accept) begin
            r_x     <= bus.X;
            r_y     <= bus.Y;
            r_idx   <= IDX_W'(WIDTH - 1);
            r_flags <= '0;
        end else if (w_finish) begin
            // Either the first differing pair or the final equal pair: the cell code is the result.
            r_flags <= w_code;
        end else if (r_state == StRun) begin
            r_idx <= r_idx - 1'b1;
            r_x   <= {r_x[WIDTH-2:0], 1'b0};
            r_y   <= {r_y[WIDTH-2:0], 1'b0};
        end
    end

    assign bus.BUSY   = (r_state == StRun);
    assign bus.DONE   = (r_state == StDone);
    assign bus.LG_OUT = r_flags[2];
    assign bus.EQ_OUT = r_flags[1];
    assign bus.RG_OUT = r_flags[0];

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// tb_serial_comp_ctrl
// Purpose : directed self-checking bench for serial_comp_ctrl at WIDTH=8.
//           Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_comp_ctrl;
    import serial_comp_pkg::*;

    localparam int unsigned W      = 8;
    localparam int          BUDGET = 40;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    serial_comp_ctrl_if #(.WIDTH(W)) bus ();

    serial_comp_ctrl #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] flags();
        return {bus.LG_OUT, bus.EQ_OUT, bus.RG_OUT};
    endfunction

    // Drives a request for one edge (E0); returns at the falling edge after E0.
    task automatic start_cmp(input logic [7:0] x, input logic [7:0] y, input bit hold);
        bus.START = 1'b1;
        bus.X     = x;
        bus.Y     = y;
        @(negedge CLK);
        if (!hold) bus.START = 1'b0;
    endtask

    // n = number of edges after E0 at which DONE is first seen; busy = BUSY cycles seen.
    task automatic wait_done(input int start_n, output int n, output int busy);
        n    = start_n;
        busy = 0;
        while (bus.DONE !== 1'b1 && n < BUDGET) begin
            if (bus.BUSY === 1'b1) busy++;
            @(negedge CLK);
            n++;
        end
    endtask

    int lat;
    int bsy;
    int dcnt;

    initial begin
        bus.START = 1'b0;
        bus.X     = '0;
        bus.Y     = '0;

        // Reset state
        #2 RST = 1'b1;
        #2;
        chk("rst_busy",  32'(bus.BUSY), 32'd0);
        chk("rst_done",  32'(bus.DONE), 32'd0);
        chk("rst_flags", 32'(flags()),  32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // 0x80 vs 0x7F: differ at MSB
        start_cmp(8'h80, 8'h7F, 1'b0);
        chk("t1_busy_now",   32'(bus.BUSY), 32'd1);
        chk("t1_flags_busy", 32'(flags()),  32'd0);
        wait_done(0, lat, bsy);
        chk("t1_latency", 32'(lat),     32'd1);
        chk("t1_busycyc", 32'(bsy),     32'd1);
        chk("t1_flags",   32'(flags()), 32'(RES_LG));
        @(negedge CLK);
        chk("t1_done_1cyc", 32'(bus.DONE), 32'd0);
        chk("t1_idle_busy", 32'(bus.BUSY), 32'd0);
        chk("t1_hold",      32'(flags()),  32'(RES_LG));
        @(negedge CLK);

        // 0x55 vs 0x55: full scan
        start_cmp(8'h55, 8'h55, 1'b0);
        wait_done(0, lat, bsy);
        chk("t2_latency", 32'(lat),     32'd8);
        chk("t2_busycyc", 32'(bsy),     32'd8);
        chk("t2_flags",   32'(flags()), 32'(RES_EQ));
        @(negedge CLK);

        // 0x12 vs 0x13, X changed to 0xFF before E3
        start_cmp(8'h12, 8'h13, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        bus.X = 8'hFF;
        wait_done(2, lat, bsy);
        chk("t3_latency", 32'(lat),     32'd8);
        chk("t3_flags",   32'(flags()), 32'(RES_RG));
        @(negedge CLK);

        // 0xC3 vs 0xC1 with an ignored START (0x00 vs 0xFF) during RUN
        start_cmp(8'hC3, 8'hC1, 1'b0);
        @(negedge CLK);
        bus.START = 1'b1;
        bus.X     = 8'h00;
        bus.Y     = 8'hFF;
        @(negedge CLK);
        bus.START = 1'b0;
        chk("t4_busy_mid",  32'(bus.BUSY), 32'd1);
        chk("t4_flags_mid", 32'(flags()),  32'd0);
        wait_done(2, lat, bsy);
        chk("t4_latency", 32'(lat),     32'd7);
        chk("t4_flags",   32'(flags()), 32'(RES_LG));
        @(negedge CLK);

        // 0x01 vs 0x02 with START held through DONE: back-to-back accept
        start_cmp(8'h01, 8'h02, 1'b1);
        wait_done(0, lat, bsy);
        chk("t5a_latency", 32'(lat),     32'd7);
        chk("t5a_flags",   32'(flags()), 32'(RES_RG));
        @(negedge CLK);
        bus.START = 1'b0;
        chk("t5_reaccept_busy",  32'(bus.BUSY), 32'd1);
        chk("t5_reaccept_done",  32'(bus.DONE), 32'd0);
        chk("t5_reaccept_flags", 32'(flags()),  32'd0);
        wait_done(0, lat, bsy);
        chk("t5b_latency", 32'(lat),     32'd7);
        chk("t5b_flags",   32'(flags()), 32'(RES_RG));
        @(negedge CLK);

        // 0x0F vs 0x0E aborted by reset before E3
        start_cmp(8'h0F, 8'h0E, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("t6_rst_busy",  32'(bus.BUSY), 32'd0);
        chk("t6_rst_done",  32'(bus.DONE), 32'd0);
        chk("t6_rst_flags", 32'(flags()),  32'd0);
        @(negedge CLK);
        RST  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.DONE === 1'b1) dcnt++;
            @(negedge CLK);
        end
        chk("t6_no_done",    32'(dcnt),     32'd0);
        chk("t6_idle_flags", 32'(flags()),  32'd0);
        start_cmp(8'h0F, 8'h0E, 1'b0);
        wait_done(0, lat, bsy);
        chk("t6_latency", 32'(lat),     32'd8);
        chk("t6_flags",   32'(flags()), 32'(RES_LG));
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_comp_ctrl.md
SERIAL_COMP_CTRL -- requirements
Module: serial_comp_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port START, input, 1 bit: request a compare of X and Y.
REQ-005 The block SHALL have ports X and Y, input, WIDTH bits each: unsigned operands, sampled only on an accepted START.
REQ-006 The block SHALL have port BUSY, output, 1 bit: high while a compare is in progress (state RUN).
REQ-007 The block SHALL have port DONE, output, 1 bit: one-cycle pulse marking the result valid.
REQ-008 The block SHALL have ports LG_OUT, EQ_OUT and RG_OUT, output, 1 bit each: result flags for X>Y, X==Y and X<Y, one-hot when valid.

Function
REQ-009 The FSM SHALL have the states IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-010 START high in IDLE or DONE SHALL be accepted at that clock edge, called E0: X and Y load into internal shift registers, the bit index loads WIDTH-1, all three flags clear to 000, and the next state is RUN.
REQ-011 START in RUN SHALL be ignored, with no change to operands, index or flags.
REQ-012 RUN SHALL examine one bit pair per cycle, MSB first: at edge Ej (j=1..WIDTH) it compares X[WIDTH-j] with Y[WIDTH-j] using the one-bit compare cell.
REQ-013 If the bits differ at edge Ej, the block SHALL register LG/EQ/RG = 100 (X bit 1) or 001 (Y bit 1) and move to DONE (early termination).
REQ-014 If the bits are equal and the index is 0, the block SHALL register 010 and move to DONE.
REQ-015 If the bits are equal and the index is greater than 0, the block SHALL decrement the index and stay in RUN.
REQ-016 Latency: DONE SHALL be high in the cycle after edge E(WIDTH-k), where k is the index of the most-significant differing bit; for equal operands it is the cycle after edge E(WIDTH).
REQ-017 The block SHALL be in state DONE for exactly one cycle and SHALL then go to IDLE, unless START is accepted in that cycle.
REQ-018 The flags SHALL hold their value from DONE until the next accepted START.
REQ-019 The flags SHALL read 000 while BUSY is high.
REQ-020 BUSY SHALL equal (state==RUN), and DONE SHALL equal (state==DONE); both SHALL come from registered state.
REQ-021 The block SHALL NOT use X and Y after E0; operand changes during RUN SHALL NOT affect the result.

Reset
REQ-022 On RST high, the block SHALL immediately drive state=IDLE, BUSY=0, DONE=0, LG_OUT=0, EQ_OUT=0, RG_OUT=0, index=0 and shift registers=0.
REQ-023 RST asserted during RUN SHALL abort the compare, with no DONE pulse and no partial result.
REQ-024 After RST deassertion, the first START SHALL be accepted normally.

Structure
REQ-025 A shared package serial_comp_pkg SHALL hold: the WIDTH default, the state encoding (IDLE/RUN/DONE) and the result codes RES_LG=3'b100, RES_EQ=3'b010, RES_RG=3'b001.
REQ-026 The one-bit compare SHALL be a sub-module comp_bit: inputs XB and YB, output a 3-bit code, purely combinational.
REQ-027 The index counter width SHALL be clog2(WIDTH).

Verification
REQ-028 Bench SHALL cover (WIDTH=8): X=0x80, Y=0x7F -> DONE in the cycle after E1, flags 100, BUSY high for 1 cycle.
REQ-029 Bench SHALL cover: X=0x55, Y=0x55 -> DONE in the cycle after E8, flags 010, BUSY high for 8 cycles.
REQ-030 Bench SHALL cover: X=0x12, Y=0x13 -> DONE in the cycle after E8, flags 001; X changed to 0xFF at E3 -> result unchanged.
REQ-031 Bench SHALL cover: START reasserted during RUN with X=0x00, Y=0xFF -> ignored; the original compare completes with its own result.
REQ-032 Bench SHALL cover: START held high through DONE with X=0x01, Y=0x02 -> back-to-back accept, flags clear to 000, second DONE with 001 in the cycle after E7 of the second compare.
REQ-033 Bench SHALL cover: RST pulsed at E3 of X=0x0F, Y=0x0E -> all outputs 0 at once, no DONE pulse; the next START completes correctly with 100.
